// File: rtl/aes_shift_rows_buf.sv
// Byte-serial ShiftRows buffer: collects 16 column-major S-box bytes and presents the permuted
// state. Optional InvShiftRows per block when AES_SR_INV_EN is defined.
module aes_shift_rows_buf #(
    parameter int unsigned DOUBLE_BUF = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_byte,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
`ifdef AES_SR_INV_EN
    input  logic         inv_i,
`endif
    output logic         err_o
);

    logic [15:0][7:0] bank_q [2];
    logic [3:0]       idx_q;
    logic             err_q;
    logic             accept, rel, idx_end, complete, frame_err;
    logic             wr_bank, rd_bank;
    logic [15:0][7:0] rd_data, perm;
    logic [1:0]       src_c;

    always_comb begin
        accept    = in_valid & in_ready;
        rel       = out_valid & out_ready;
        idx_end   = (idx_q == 4'd15);
        complete  = accept & idx_end & in_last;
        frame_err = accept & (in_last != idx_end);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= frame_err;
            if (accept) begin
                // Both a completed block and a framing error restart the fill at slot 0.
                idx_q <= (in_last || idx_end) ? 4'd0 : idx_q + 4'd1;
            end
        end
    end

    // Datapath storage needs no reset; out_state is gated by out_valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            bank_q[wr_bank][4'd15 - idx_q] <= in_byte;
        end
    end

`ifdef AES_SR_INV_EN
    logic [1:0] inv_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inv_q <= '0;
        end else if (accept && idx_q == 4'd0) begin
            inv_q[wr_bank] <= inv_i;
        end
    end
`endif

    if (DOUBLE_BUF != 0) begin : g_double
        logic [1:0] full_q, full_d;
        logic       wp_q, rp_q;

        // Completion and release never target the same bank in one cycle.
        always_comb begin
            full_d = full_q;
            if (complete) full_d[wp_q] = 1'b1;
            if (rel)      full_d[rp_q] = 1'b0;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                full_q <= '0;
                wp_q   <= 1'b0;
                rp_q   <= 1'b0;
            end else begin
                full_q <= full_d;
                wp_q   <= wp_q ^ complete;
                rp_q   <= rp_q ^ rel;
            end
        end

        always_comb begin
            in_ready  = !full_q[wp_q];
            out_valid = full_q[rp_q];
            wr_bank   = wp_q;
            rd_bank   = rp_q;
        end
    end else begin : g_single
        typedef enum logic {StFill, StHold} state_e;
        state_e state_q, state_d;

        always_comb begin
            state_d = state_q;
            unique case (state_q)
                StFill:  if (complete) state_d = StHold;
                StHold:  if (rel)      state_d = StFill;
                default: state_d = StFill;
            endcase
        end

        always_ff @(posedge clk) begin
            if (!rst_n) state_q <= StFill;
            else        state_q <= state_d;
        end

        always_comb begin
            in_ready  = (state_q == StFill);
            out_valid = (state_q == StHold);
            wr_bank   = 1'b0;
            rd_bank   = 1'b0;
        end
    end

    // Byte 4c+r sits at packed index 15-(4c+r); row r rotates by r columns.
    always_comb begin
        rd_data = bank_q[rd_bank];
        perm    = '0;
        src_c   = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src_c = 2'(c + r);
`ifdef AES_SR_INV_EN
                if (inv_q[rd_bank]) src_c = 2'(c - r);
`endif
                perm[4'(15 - (4 * c + r))] = rd_data[4'(15 - (4 * int'(src_c) + r))];
            end
        end
        out_state = out_valid ? perm : '0;
        err_o     = err_q;
    end

endmodule
